// File: rtl/ff_serializer_if.sv
// rtl/ff_serializer_if.sv - load-side and serial-side handshake bundle for ff_serializer
interface ff_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             ld;
  logic             ld_ready;
  logic             out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  modport master (
    output in, ld, out_ready,
    input  ld_ready, out, out_valid, busy, done
  );

  modport slave (
    input  in, ld, out_ready,
    output ld_ready, out, out_valid, busy, done
  );
endinterface

// File: rtl/ff_serializer.sv
// rtl/ff_serializer.sv - parallel-in serial-out transmitter with load/valid/ready handshake
module ff_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  ff_serializer_if.slave    bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             last;
  logic             ld_ready;
  logic             head_bit;
  logic [WIDTH-1:0] shifted;

  assign last     = (cnt_q == CNT_LAST);
  assign ld_ready = (state_q == IDLE) || ((state_q == SHIFT) && last && bus.out_ready);
  assign head_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  // Zero fill keeps the vacated end clean so a stale bit can never reach out.
  assign shifted  = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};

  assign bus.ld_ready  = ld_ready;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.out_valid = (state_q == SHIFT);
  assign bus.out       = (state_q == SHIFT) ? head_bit : 1'b0;
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ld) begin
          shreg_d = bus.in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.out_ready) begin
          if (!last) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            // Final bit accepted: a pending load chains straight in with no bubble.
            done_d = 1'b1;
            cnt_d  = '0;
            if (bus.ld) begin
              shreg_d = bus.in;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ff_serializer.sv
// tb/tb_ff_serializer.sv - self-checking bench for ff_serializer, LSB-first and MSB-first instances
module tb_ff_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_s = '0;
  logic         ld_s = 1'b0;
  logic         rdy_s = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  ff_serializer_if #(.WIDTH(W)) ifl ();
  ff_serializer_if #(.WIDTH(W)) ifm ();

  assign ifl.in = in_s;
  assign ifl.ld = ld_s;
  assign ifl.out_ready = rdy_s;
  assign ifm.in = in_s;
  assign ifm.ld = ld_s;
  assign ifm.out_ready = rdy_s;

  ff_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(ifl));
  ff_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst(rst), .bus(ifm));

  always #5 clk = ~clk;

  // Model: queue of bits still owed for the current word, front is on the wire.
  bit mq_l[$];
  bit mq_m[$];
  bit md_l = 1'b0;
  bit md_m = 1'b0;

  // Observed stream, for literal checks against hand-computed sequences.
  logic [31:0] seq_l, seq_m;
  int n_l, n_m, dn_l, dn_m;

  task automatic cmp(string nm, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit lr_l, lr_m, v_l, v_m;
    if (rst) begin
      mq_l.delete();
      mq_m.delete();
      md_l = 1'b0;
      md_m = 1'b0;
    end
    v_l  = (mq_l.size() != 0);
    v_m  = (mq_m.size() != 0);
    lr_l = !v_l || (mq_l.size() == 1 && rdy_s);
    lr_m = !v_m || (mq_m.size() == 1 && rdy_s);

    cmp("L.out_valid", ifl.out_valid, v_l);
    cmp("L.busy",      ifl.busy,      v_l);
    cmp("L.out",       ifl.out,       v_l ? mq_l[0] : 1'b0);
    cmp("L.done",      ifl.done,      md_l);
    cmp("L.ld_ready",  ifl.ld_ready,  lr_l);
    cmp("M.out_valid", ifm.out_valid, v_m);
    cmp("M.busy",      ifm.busy,      v_m);
    cmp("M.out",       ifm.out,       v_m ? mq_m[0] : 1'b0);
    cmp("M.done",      ifm.done,      md_m);
    cmp("M.ld_ready",  ifm.ld_ready,  lr_m);

    if (ifl.out_valid && rdy_s) begin seq_l = {seq_l[30:0], ifl.out}; n_l++; end
    if (ifm.out_valid && rdy_s) begin seq_m = {seq_m[30:0], ifm.out}; n_m++; end
    if (ifl.done) dn_l++;
    if (ifm.done) dn_m++;

    if (!rst) begin
      md_l = v_l && rdy_s && (mq_l.size() == 1);
      md_m = v_m && rdy_s && (mq_m.size() == 1);
      if (v_l && rdy_s) void'(mq_l.pop_front());
      if (v_m && rdy_s) void'(mq_m.pop_front());
      if (ld_s && lr_l) for (int i = 0; i < W; i++) mq_l.push_back(in_s[i]);
      if (ld_s && lr_m) for (int i = 0; i < W; i++) mq_m.push_back(in_s[W-1-i]);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    seq_l = '0; seq_m = '0;
    n_l = 0; n_m = 0; dn_l = 0; dn_m = 0;
  endtask

  task automatic load1(logic [W-1:0] w);
    in_s = w;
    ld_s = 1'b1;
    tick(1);
    ld_s = 1'b0;
  endtask

  initial begin
    clr();
    tick(2);
    rst = 1'b0;
    chk("reset.ld_ready", int'(ifl.ld_ready), 1);
    chk("reset.out_valid", int'(ifl.out_valid), 0);

    // Single word 8'hA5
    clr();
    load1(8'hA5);
    tick(10);
    chk("A5.L.seq", int'(seq_l), 32'hA5);
    chk("A5.M.seq", int'(seq_m), 32'hA5);
    chk("A5.L.bits", n_l, 8);
    chk("A5.L.done", dn_l, 1);
    chk("A5.busy", int'(ifl.busy), 0);

    // 8'h0F: LSB-first sends 1111_0000, MSB-first 0000_1111
    clr();
    load1(8'h0F);
    tick(10);
    chk("0F.L.seq", int'(seq_l), 32'hF0);
    chk("0F.M.seq", int'(seq_m), 32'h0F);

    // Back-pressure on bit 2 of 8'h3C
    clr();
    load1(8'h3C);
    tick(2);
    rdy_s = 1'b0;
    tick(2);
    chk("bp.out_valid", int'(ifl.out_valid), 1);
    chk("bp.L.out", int'(ifl.out), 1);
    tick(1);
    rdy_s = 1'b1;
    tick(10);
    chk("3C.L.seq", int'(seq_l), 32'h3C);
    chk("3C.M.seq", int'(seq_m), 32'h3C);
    chk("3C.L.done", dn_l, 1);

    // Load request mid-word must be ignored
    clr();
    load1(8'hFF);
    tick(4);
    in_s = 8'h00;
    ld_s = 1'b1;
    chk("ign.ld_ready", int'(ifl.ld_ready), 0);
    tick(1);
    ld_s = 1'b0;
    tick(8);
    chk("FF.L.seq", int'(seq_l), 32'hFF);
    chk("FF.L.bits", n_l, 8);
    chk("FF.M.done", dn_m, 1);

    // Back-to-back words with ld held high
    clr();
    in_s = 8'h81;
    ld_s = 1'b1;
    tick(1);
    in_s = 8'h7E;
    tick(8);
    ld_s = 1'b0;
    tick(10);
    chk("b2b.L.seq", int'(seq_l), 32'h817E);
    chk("b2b.M.seq", int'(seq_m), 32'h817E);
    chk("b2b.L.bits", n_l, 16);
    chk("b2b.L.done", dn_l, 2);

    // Asynchronous reset while bit 3 of 8'hFF is on the wire
    clr();
    load1(8'hFF);
    tick(3);
    chk("pre_rst.out", int'(ifl.out), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst.L.out", int'(ifl.out), 0);
    chk("rst.L.out_valid", int'(ifl.out_valid), 0);
    chk("rst.M.busy", int'(ifm.busy), 0);
    chk("rst.L.done", int'(ifl.done), 0);
    tick(1);
    rst = 1'b0;
    chk("post_rst.ld_ready", int'(ifl.ld_ready), 1);
    tick(2);
    chk("post_rst.done", dn_l, 0);
    clr();
    load1(8'h01);
    tick(10);
    chk("01.L.seq", int'(seq_l), 32'h80);
    chk("01.M.seq", int'(seq_m), 32'h01);
    chk("01.L.done", dn_l, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ff_serializer.md
Name: ff_serializer

Overview:
- Parallel-in, serial-out transmitter with a load/valid/ready handshake.
- Takes a WIDTH-bit word on a load strobe and emits it one bit per accepted cycle to a downstream serial consumer.
- The upstream side is the ld/in load-enable register interface used throughout the component library; the downstream side is a valid/ready bit stream.
- Provides back-pressure upstream through ld_ready and a one-cycle done pulse per word.

Parameters:
- WIDTH, 8, word width in bits; legal range ≥ 2.
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 transmitted first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  parallel word; sampled only when a load is accepted.
- ld  input  1  load request; accepted when ld && ld_ready at a rising clk edge.
- ld_ready  output  1  combinational; block can accept a load this cycle.
- out  output  1  current serial bit; 0 whenever out_valid = 0.
- out_valid  output  1  out holds a valid bit.
- out_ready  input  1  downstream accepts out this cycle.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse after the last bit of a word is accepted.

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE; shift register = 0; bit counter = 0.
  - out = 0, out_valid = 0, busy = 0, done = 0.
  - ld_ready = 1 as soon as rst deasserts.
  - Reset mid-word abandons the word; no done pulse.
- States: IDLE, SHIFT.
- Definitions:
  - transfer = out_valid && out_ready.
  - last = (cnt == WIDTH-1).
  - ld_ready = (state == IDLE) || (state == SHIFT && last && out_ready).
- IDLE:
  - On ld && ld_ready: shreg <= in, cnt <= 0, state <= SHIFT.
  - out_valid is asserted the next cycle, with out = first bit (in[0] if LSB_FIRST, else in[WIDTH-1]).
  - Load latency: first bit is visible one cycle after the load edge.
- SHIFT:
  - out_valid = 1 and busy = 1 for the whole state.
  - out = shreg[0] (LSB_FIRST) or shreg[WIDTH-1].
  - transfer && !last: shift shreg one position toward the output end (zero fill), cnt <= cnt + 1.
  - transfer && last && !ld: state <= IDLE, done <= 1 next cycle.
  - transfer && last && ld: done <= 1 next cycle; reload shreg from in, cnt <= 0, stay in SHIFT. Back-to-back words have no bubble cycle.
  - !out_ready: shreg, cnt and out hold; out and out_valid stay stable until accepted.
- ld while ld_ready = 0 is ignored; in is not sampled.
- ld and in are don't-care in IDLE unless both ld and ld_ready are high.
- done:
  - Registered; high exactly one cycle per completed word.
  - Never asserted by reset.
  - Independent of out_ready in the pulse cycle.
- Each word takes exactly WIDTH transfers.
- cnt width = clog2(WIDTH); cnt never exceeds WIDTH-1.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while SHIFT on bit 3 of 8 → out, out_valid, busy, done drop to 0 immediately without a clock edge. After release, ld_ready = 1 and the next load starts at bit 0.
- Single word, LSB_FIRST=1, WIDTH=8, out_ready=1: load in=8'hA5 → out_valid rises one cycle later; out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; done pulses on the cycle after the 8th transfer; busy returns to 0.
- MSB-first: LSB_FIRST=0, load 8'hA5 → out sequence 1,0,1,0,0,1,0,1 read from bit 7 down; with 8'h0F → 0,0,0,0,1,1,1,1.
- Back-pressure: load 8'h3C, hold out_ready=0 for 3 cycles after bit 2 → out and out_valid frozen for 3 cycles; sequence unchanged (0,0,1,1,1,1,0,0); done pulses exactly once, 8 transfers after the load.
- Ignored load: during SHIFT of 8'hFF, pulse ld with in=8'h00 at bit 4 → ignored (ld_ready = 0), output remains all ones, busy falls after the 8th bit.
- Back-to-back: hold ld=1 with in=8'h81 then 8'h7E, out_ready=1 → 16 contiguous valid bits (1,0,0,0,0,0,0,1, 0,1,1,1,1,1,1,0); done pulses at cycles 9 and 17 after the first load; out_valid never drops between words.
